// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : priority_encoder
//  Purpose  : Highest-index-wins priority encoder with a registered result.
//             Reports the index of the most-significant set bit of the
//             request vector one clock after it is sampled. A valid flag
//             separates "no request" from "request 0".
//  Ports    : clk    - single clock, rising-edge
//             rst    - asynchronous, active-high reset
//             in     - request vector [WIDTH-1:0], bit i = request i
//             out    - registered index of the highest set bit [OUT_W-1:0]
//             valid  - registered, 1 when the sampled vector was non-zero
//             onehot - registered one-hot of out [WIDTH-1:0]
//                      (present only when PRIO_ENC_ONEHOT_EN is defined)
//  Options  : `define PRIO_ENC_ONEHOT_EN to add the onehot output.
//  Revision : 1.0 - initial release
// ============================================================================
module priority_encoder #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in,
  output logic [$clog2(WIDTH)-1:0]  out,
`ifdef PRIO_ENC_ONEHOT_EN
  output logic [WIDTH-1:0]          onehot,
`endif
  output logic                      valid
);

  localparam int OUT_W = $clog2(WIDTH);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  // Ascending scan where each later hit overwrites the earlier one; the
  // final value is therefore the highest set index, which is the same
  // result as a top-down search. The index can never exceed WIDTH-1,
  // even when WIDTH is not a power of two.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        w_idx = OUT_W'(i);
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef PRIO_ENC_ONEHOT_EN
  logic [WIDTH-1:0] w_onehot;
  logic [WIDTH-1:0] r_onehot;

  // Same overwrite scan: only the highest set bit survives, and an
  // all-zero request leaves the vector all zeros.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_onehot <= '0;
    end else begin
      r_onehot <= w_onehot;
    end
  end

  assign onehot = r_onehot;
`endif

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_encoder
//  Purpose  : Directed self-checking bench for priority_encoder (WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_priority_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [7:0] onehot;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  priority_encoder #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
`ifdef PRIO_ENC_ONEHOT_EN
    .onehot (onehot),
`endif
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // floor(log2(v)) for v>0, via clog2(v+1)-1; 0 for v==0.
  function automatic logic [2:0] msb_idx(input logic [7:0] v);
    int t;
    if (v == 8'd0) return 3'd0;
    t = $clog2(int'(v) + 1) - 1;
    return t[2:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Drive a vector away from the active edge, then sample just after the
  // next rising edge.
  task automatic step(input logic [7:0] v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in  = 8'h00;

    // Reset state (asynchronous, no clock edge needed)
    #1 rst = 1'b1;
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
`ifdef PRIO_ENC_ONEHOT_EN
    check("reset_onehot", 32'(onehot), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Examples and priority cases
    step(8'b0000_0001); check("ex_01_out", 32'(out), 32'd0);
                        check("ex_01_valid", 32'(valid), 32'd1);
    step(8'b1000_0001); check("ex_81_out", 32'(out), 32'd7);
    step(8'b0011_0110); check("ex_36_out", 32'(out), 32'd5);
    step(8'b1111_1111); check("prio_ff_out", 32'(out), 32'd7);
    step(8'b0000_0011); check("prio_03_out", 32'(out), 32'd1);
    step(8'b0100_1000); check("prio_48_out", 32'(out), 32'd6);

    // Single bits, then all-zero
    for (int k = 0; k < 8; k++) begin
      step(8'(1 << k));
      check($sformatf("single_%0d_out", k), 32'(out), 32'(k));
      check($sformatf("single_%0d_valid", k), 32'(valid), 32'd1);
    end
    step(8'h00);
    check("zero_out", 32'(out), 32'd0);
    check("zero_valid", 32'(valid), 32'd0);

    // Back-to-back with no bubble
    step(8'h80); check("b2b_80_out", 32'(out), 32'd7);
    step(8'h01); check("b2b_01_out", 32'(out), 32'd0);
                 check("b2b_01_valid", 32'(valid), 32'd1);

`ifdef PRIO_ENC_ONEHOT_EN
    step(8'b0011_0000); check("oh_30", 32'(onehot), 32'h20);
    step(8'b0101_0000); check("oh_50", 32'(onehot), 32'h40);
    step(8'h00);        check("oh_00", 32'(onehot), 32'h00);
`endif

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      step(8'(v));
      check($sformatf("sweep_%02h_out", v), 32'(out), 32'(msb_idx(8'(v))));
      check($sformatf("sweep_%02h_valid", v), 32'(valid),
            32'(v != 0));
`ifdef PRIO_ENC_ONEHOT_EN
      check($sformatf("sweep_%02h_onehot", v), 32'(onehot),
            (v == 0) ? 32'd0 : (32'd1 << msb_idx(8'(v))));
`endif
    end

    // Mid-run asynchronous reset with all requests active
    step(8'hFF);
    check("pre_rst_out", 32'(out), 32'd7);
    check("pre_rst_valid", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_rst_out", 32'(out), 32'd0);
    check("hold_rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_out", 32'(out), 32'd7);
    check("post_rst_valid", 32'(valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
